// File: rtl/fifo_serializer_if.sv
// Handshake bundle between the upstream FIFO read port and the serial transmitter.
interface fifo_serializer_if;
  logic       empty;
  logic [7:0] fifo_data;
  logic       pop;
  logic       tx;
  logic       busy;
  logic       frame_done;

  modport master (
    input  empty,
    input  fifo_data,
    output pop,
    output tx,
    output busy,
    output frame_done
  );

  modport slave (
    output empty,
    output fifo_data,
    input  pop,
    input  tx,
    input  busy,
    input  frame_done
  );
endinterface

// File: rtl/fifo_serializer.sv
// Pops bytes from an upstream FIFO and sends them as start/8 data LSB-first/stop frames.
// Define FIFO_SERIALIZER_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_serializer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_serializer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [7:0] LAST = 8'(BIT_CYCLES - 1);

  state_t     state, nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] sh, sh_nxt;
  logic       bit_end;
  logic       tx_q, tx_nxt;
  logic       pop_q, busy_q, done_q;
`ifdef FIFO_SERIALIZER_PARITY_EN
  logic       par_q, par_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      tx_q   <= 1'b1;
      pop_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      sh     <= sh_nxt;
      // Outputs are registered from the next state so they line up with it.
      tx_q   <= tx_nxt;
      pop_q  <= (nxt == POP);
      busy_q <= (nxt != IDLE);
      done_q <= (state == STOP) && (nxt == IDLE);
    end
  end

`ifdef FIFO_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_nxt;
  end
`endif

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    idx_nxt = idx;
    sh_nxt  = sh;
    bit_end = (cnt == LAST);
`ifdef FIFO_SERIALIZER_PARITY_EN
    par_nxt = par_q;
`endif
    case (state)
      IDLE: begin
        if (!bus.empty) nxt = POP;
      end
      POP: begin
        nxt = LOAD;
      end
      LOAD: begin
        sh_nxt  = bus.fifo_data;
        cnt_nxt = '0;
        nxt     = START;
`ifdef FIFO_SERIALIZER_PARITY_EN
        par_nxt = ^bus.fifo_data;
`endif
      end
      START: begin
        if (bit_end) begin
          cnt_nxt = '0;
          idx_nxt = '0;
          nxt     = DATA;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          sh_nxt  = {1'b0, sh[7:1]};
          if (idx == 3'd7) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
            nxt = PARITY;
`else
            nxt = STOP;
`endif
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
`ifdef FIFO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_nxt = '0;
          nxt     = STOP;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          nxt     = IDLE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase

    // The shift register already holds the next bit in bit 0 once shifted.
    case (nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
`ifdef FIFO_SERIALIZER_PARITY_EN
      PARITY:  tx_nxt = par_q;
`endif
      default: tx_nxt = 1'b1;
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.pop        = pop_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 The block SHALL have parameter BIT_CYCLES, default 4, giving clock cycles per serial bit (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all flops are rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port empty, input, 1 bit: upstream FIFO empty flag.
REQ-005 The block SHALL have port fifo_data, input, 8 bits: upstream FIFO registered read data, valid in the cycle after a pop.
REQ-006 The block SHALL have port pop, output, 1 bit: FIFO read strobe, registered.
REQ-007 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse on frame completion.

Function
REQ-010 The block SHALL implement the states IDLE, POP, LOAD, START, DATA, PARITY and STOP.
REQ-011 In IDLE with empty=0, the FSM SHALL move to POP on the next edge; with empty=1 it SHALL stay in IDLE.
REQ-012 The pop output SHALL be 1 only while in POP, for exactly one cycle per byte, and never when IDLE sampled empty=1.
REQ-013 The FSM SHALL pass POP->LOAD unconditionally, and LOAD SHALL capture fifo_data into an 8-bit shift register at its closing edge.
REQ-014 The empty input SHALL be ignored in every state other than IDLE.
REQ-015 START SHALL drive tx=0 for BIT_CYCLES cycles.
REQ-016 DATA SHALL send 8 bits LSB first, each held BIT_CYCLES cycles, counted by a bit-period counter and a 3-bit index.
REQ-017 STOP SHALL drive tx=1 for BIT_CYCLES cycles and then return to IDLE.
REQ-018 frame_done SHALL be 1 in the first IDLE cycle after STOP.
REQ-019 tx SHALL be 1 in IDLE, POP and LOAD; tx SHALL be registered and glitch-free.
REQ-020 Latency: the tx falling edge SHALL occur 3 cycles after IDLE samples empty=0.
REQ-021 Byte-to-byte period with empty held low SHALL be 3+10*BIT_CYCLES cycles (3+11*BIT_CYCLES with parity).

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, tx=1, pop=0, busy=0, frame_done=0, shift register=0 and counters=0.
REQ-023 A reset mid-frame SHALL abort the frame; the popped byte is lost and SHALL NOT be retransmitted.
REQ-024 After rst_n rises, the block SHALL behave as IDLE on the first clock edge.

Configuration
REQ-025 With macro FIFO_SERIALIZER_PARITY_EN defined, the FSM SHALL pass DATA->PARITY->STOP, and PARITY SHALL drive the even-parity bit (XOR of the 8 data bits) for BIT_CYCLES cycles.
REQ-026 Without FIFO_SERIALIZER_PARITY_EN, PARITY SHALL be unreachable, DATA SHALL go directly to STOP, and no parity logic SHALL be synthesized.

Verification (BIT_CYCLES=4)
REQ-027 Reset check: rst_n=0 -> tx=1, pop=0, busy=0, frame_done=0, including reset asserted between clock edges.
REQ-028 Single byte: empty falls with fifo_data=8'h01 ->
- pop high exactly one cycle;
- tx low 4 cycles, then high 4, then low 28, then high 4;
- frame_done pulses once, 43 cycles after empty sampled low.
REQ-029 Back-to-back: 8'h02 then 8'h03 with empty low throughout -> two pops exactly 43 cycles apart, and both bytes appear LSB-first on tx.
REQ-030 Empty held high for 100 cycles -> pop never asserted, tx=1, busy=0.
REQ-031 Mid-frame reset: rst_n=0 during DATA of 8'hA5 ->
- tx=1 within the same cycle;
- after release with empty=0, a new pop occurs 1 cycle later;
- 8'hA5 is never completed.
REQ-032 Parity: with FIFO_SERIALIZER_PARITY_EN and byte 8'h07 -> parity bit=1 for 4 cycles, and the frame is 44 cycles long.
